// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: scancode constants and frame FSM states.
package ps2_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned KEY_W  = 11;

  localparam logic [BYTE_W-1:0] SC_E0     = 8'hE0;
  localparam logic [BYTE_W-1:0] SC_F0     = 8'hF0;
  localparam logic [BYTE_W-1:0] SC_E1     = 8'hE1;
  localparam logic [BYTE_W-1:0] SC_ACK    = 8'hFA;
  localparam logic [BYTE_W-1:0] SC_BAT    = 8'hAA;
  localparam logic [BYTE_W-1:0] SC_ECHO   = 8'hEE;
  localparam logic [BYTE_W-1:0] SC_RESEND = 8'hFE;
  localparam logic [BYTE_W-1:0] SC_ERR0   = 8'h00;
  localparam logic [BYTE_W-1:0] SC_ERRF   = 8'hFF;

  // Bytes of the Pause sequence that follow the E1 lead-in.
  localparam logic [2:0] PAUSE_SWALLOW = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

endpackage

// File: rtl/ps2_filter.sv
// 2-FF synchroniser, FILT_LEN stability filter and falling-edge strobe for ps2_clk.
module ps2_filter #(
  parameter int unsigned FILT_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_fall
);

  localparam int unsigned CW = $clog2(FILT_LEN + 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_fclk;
  logic          r_fclk_q;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Synchronise, accept a new level only after FILT_LEN stable cycles, strobe on 1->0.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_fclk   <= 1'b1;
      r_fclk_q <= 1'b1;
      r_fall   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1     <= i_raw;
      r_s2     <= r_s1;
      r_fclk_q <= r_fclk;
      r_fall   <= r_fclk_q & ~r_fclk;
      if (r_s2 == r_fclk) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILT_LEN - 1)) begin
        r_fclk <= r_s2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_fall = r_fall;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 receiver: frame deserialiser plus E0/F0/E1 prefix decoder producing toggle-flagged key events.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILT_LEN    = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic [KEY_W-1:0]  ps2_key,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic              w_fall;
  logic              w_data;
  logic [BYTE_W-1:0] w_byte;
  logic              w_frame_ok;

  logic              r_d1;
  logic              r_d2;
  ps2_state_e        r_state;
  logic [2:0]        r_bit_cnt;
  logic [BYTE_W-1:0] r_shift;
  logic              r_par;
  logic [TW-1:0]     r_to_cnt;
  logic              r_ext;
  logic              r_rel;
  logic [2:0]        r_swallow;
  logic [KEY_W-1:0]  r_key;
  logic              r_err;
  logic              r_busy;

  ps2_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_clk_filter (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_raw   (ps2_clk),
    .o_fall  (w_fall)
  );

  // Data line only needs synchronising; it is sampled on filtered clock edges.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_d1 <= 1'b1;
      r_d2 <= 1'b1;
    end else begin
      r_d1 <= ps2_data;
      r_d2 <= r_d1;
    end
  end

  assign w_data     = r_d2;
  assign w_byte     = r_shift;
  assign w_frame_ok = ((^r_shift) ^ r_par) & w_data;

  // Frame FSM, timeout and byte decoder.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
      r_ext     <= 1'b0;
      r_rel     <= 1'b0;
      r_swallow <= '0;
      r_key     <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_err <= 1'b0;

      if (r_state == ST_IDLE || w_fall) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            if (!w_data) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
              r_busy    <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_fall) begin
            r_shift <= {w_data, r_shift[BYTE_W-1:1]};
            if (r_bit_cnt == 3'd7) begin
              r_state <= ST_PARITY;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_fall) begin
            r_par   <= w_data;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_fall) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            if (!w_frame_ok) begin
              r_err <= 1'b1;
              r_ext <= 1'b0;
              r_rel <= 1'b0;
            end else if (r_swallow != 3'd0) begin
              r_swallow <= r_swallow - 3'd1;
            end else begin
              case (w_byte)
                SC_E0: r_ext <= 1'b1;
                SC_F0: r_rel <= 1'b1;
                SC_E1: r_swallow <= PAUSE_SWALLOW;
                SC_ACK, SC_BAT, SC_ECHO, SC_RESEND, SC_ERR0, SC_ERRF: begin
                  r_ext <= 1'b0;
                  r_rel <= 1'b0;
                end
                default: begin
                  r_key <= {~r_key[KEY_W-1], ~r_rel, r_ext, w_byte};
                  r_ext <= 1'b0;
                  r_rel <= 1'b0;
                end
              endcase
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // A coincident fall keeps the frame alive; otherwise abandon a stalled frame.
      if (!w_fall && r_state != ST_IDLE && r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
        r_state  <= ST_IDLE;
        r_busy   <= 1'b0;
        r_err    <= 1'b1;
        r_ext    <= 1'b0;
        r_rel    <= 1'b0;
        r_to_cnt <= '0;
      end
    end
  end

  assign ps2_key   = r_key;
  assign frame_err = r_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed vector table, corner sequences, random frames vs. a model.
module tb_ps2_rx;

  localparam int unsigned FILT_LEN    = 8;
  localparam int unsigned TIMEOUT_CYC = 2000;

  logic        clk_sys  = 1'b0;
  logic        reset_n  = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;

  // Reference model state (spec-level decoder behaviour).
  logic [10:0] m_key;
  bit          m_ext;
  bit          m_rel;
  int          m_swallow;

  typedef struct {
    logic [7:0]  b;
    bit          bad_par;
    bit          bad_stop;
    logic [10:0] exp_key;
    int          exp_err;
  } vec_t;

  vec_t tbl [32];

  ps2_rx #(
    .FILT_LEN    (FILT_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) if (frame_err) err_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_key = '0; m_ext = 0; m_rel = 0; m_swallow = 0;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_ext = 0; m_rel = 0;
    end else if (m_swallow > 0) begin
      m_swallow--;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_rel = 1;
    else if (b == 8'hE1) m_swallow = 7;
    else if (b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFE || b == 8'h00 || b == 8'hFF) begin
      m_ext = 0; m_rel = 0;
    end else begin
      m_key = {~m_key[10], ~m_rel, m_ext, b};
      m_ext = 0; m_rel = 0;
    end
  endfunction

  task automatic send_bit(input bit v);
    @(negedge clk_sys); ps2_data = v;
    repeat (10) @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk_sys);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk_sys);
  endtask

  initial begin
    int e0;
    int lat;
    int r;
    logic [7:0] b;
    bit bad, bp, bs;

    tbl[0]  = '{8'h1C, 0, 0, 11'h61C, 0};
    tbl[1]  = '{8'h1C, 0, 0, 11'h21C, 0};
    tbl[2]  = '{8'hF0, 0, 0, 11'h21C, 0};
    tbl[3]  = '{8'h1C, 0, 0, 11'h41C, 0};
    tbl[4]  = '{8'hE0, 0, 0, 11'h41C, 0};
    tbl[5]  = '{8'hF0, 0, 0, 11'h41C, 0};
    tbl[6]  = '{8'h75, 0, 0, 11'h175, 0};
    tbl[7]  = '{8'hE0, 0, 0, 11'h175, 0};
    tbl[8]  = '{8'h75, 0, 0, 11'h775, 0};
    tbl[9]  = '{8'hF0, 0, 0, 11'h775, 0};
    tbl[10] = '{8'h1C, 1, 0, 11'h775, 1};
    tbl[11] = '{8'h1C, 0, 0, 11'h21C, 0};
    tbl[12] = '{8'hE0, 0, 0, 11'h21C, 0};
    tbl[13] = '{8'h1C, 0, 1, 11'h21C, 1};
    tbl[14] = '{8'h1C, 0, 0, 11'h61C, 0};
    tbl[15] = '{8'hE1, 0, 0, 11'h61C, 0};
    tbl[16] = '{8'h14, 0, 0, 11'h61C, 0};
    tbl[17] = '{8'h77, 0, 0, 11'h61C, 0};
    tbl[18] = '{8'hE1, 0, 0, 11'h61C, 0};
    tbl[19] = '{8'hF0, 0, 0, 11'h61C, 0};
    tbl[20] = '{8'h14, 0, 0, 11'h61C, 0};
    tbl[21] = '{8'hF0, 0, 0, 11'h61C, 0};
    tbl[22] = '{8'h77, 0, 0, 11'h61C, 0};
    tbl[23] = '{8'h1C, 0, 0, 11'h21C, 0};
    tbl[24] = '{8'hAA, 0, 0, 11'h21C, 0};
    tbl[25] = '{8'hFA, 0, 0, 11'h21C, 0};
    tbl[26] = '{8'hF0, 0, 0, 11'h21C, 0};
    tbl[27] = '{8'hAA, 0, 0, 11'h21C, 0};
    tbl[28] = '{8'h1C, 0, 0, 11'h61C, 0};
    tbl[29] = '{8'hF0, 0, 0, 11'h61C, 0};
    tbl[30] = '{8'hE0, 0, 0, 11'h61C, 0};
    tbl[31] = '{8'h75, 0, 0, 11'h175, 0};

    model_reset();
    repeat (3) @(negedge clk_sys);
    check("reset_key", 32'(ps2_key), 32'h0);
    check("reset_err", 32'(frame_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);

    // Directed vector table.
    for (int i = 0; i < 32; i++) begin
      e0 = err_cnt;
      send_frame(tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop);
      model_frame(tbl[i].b, !(tbl[i].bad_par || tbl[i].bad_stop));
      check($sformatf("tbl%0d_key", i), 32'(ps2_key), 32'(tbl[i].exp_key));
      check($sformatf("tbl%0d_err", i), 32'(err_cnt - e0), 32'(tbl[i].exp_err));
    end
    check("tbl_busy_idle", 32'(busy), 32'h0);

    // Start bit sampled high: one error, nothing else.
    e0 = err_cnt;
    send_bit(1'b1);
    repeat (20) @(negedge clk_sys);
    check("badstart_err", 32'(err_cnt - e0), 32'h1);
    check("badstart_busy", 32'(busy), 32'h0);
    check("badstart_key", 32'(ps2_key), 32'(m_key));

    // Timeout after a partial frame.
    e0 = err_cnt;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    check("to_busy_hi", 32'(busy), 32'h1);
    repeat (TIMEOUT_CYC + 50) @(negedge clk_sys);
    check("to_busy_lo", 32'(busy), 32'h0);
    check("to_err", 32'(err_cnt - e0), 32'h1);
    model_frame(8'h00, 1'b0);
    send_frame(8'h1C, 0, 0);
    model_frame(8'h1C, 1'b1);
    check("to_next_key", 32'(ps2_key), 32'(m_key));

    // Start-bit fall latency: busy rises one cycle after fall (2 + FILT_LEN + 1 after edge).
    @(negedge clk_sys); ps2_data = 1'b0;
    repeat (10) @(negedge clk_sys);
    ps2_clk = 1'b0;
    lat = 0;
    while (!busy && lat < 50) begin
      @(negedge clk_sys);
      lat++;
    end
    check("fall_latency", 32'(lat), 32'(2 + FILT_LEN + 1 + 1));
    repeat (10) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk_sys);
    b = 8'h2B;
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b);
    send_bit(1'b1);
    repeat (20) @(negedge clk_sys);
    model_frame(b, 1'b1);
    check("lat_frame_key", 32'(ps2_key), 32'(m_key));

    // Short ps2_clk glitches are filtered out.
    e0 = err_cnt;
    r = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys); ps2_clk = 1'b0;
      for (int k = 0; k < 4; k++) begin @(negedge clk_sys); if (busy) r++; end
      ps2_clk = 1'b1;
      for (int k = 0; k < 12; k++) begin @(negedge clk_sys); if (busy) r++; end
    end
    check("glitch_busy", 32'(r), 32'h0);
    check("glitch_err", 32'(err_cnt - e0), 32'h0);

    // Random frames against the model.
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = (n % 3 == 0) ? 8'hE1 : 8'hAA;
        3: b = 8'hF0;
        default: b = 8'($urandom);
      endcase
      bad = ($urandom_range(0, 7) == 0);
      bp  = bad && ($urandom_range(0, 1) == 0);
      bs  = bad && !bp;
      e0 = err_cnt;
      send_frame(b, bp, bs);
      model_frame(b, !bad);
      check($sformatf("rnd%0d_key", n), 32'(ps2_key), 32'(m_key));
      check($sformatf("rnd%0d_err", n), 32'(err_cnt - e0), bad ? 32'h1 : 32'h0);
    end

    // Reset mid-frame clears everything asynchronously.
    send_bit(1'b0); send_bit(1'b1);
    @(negedge clk_sys); ps2_clk = 1'b0;
    repeat (15) @(negedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    check("mrst_key", 32'(ps2_key), 32'h0);
    check("mrst_busy", 32'(busy), 32'h0);
    check("mrst_err", 32'(frame_err), 32'h0);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    model_reset();
    repeat (5) @(negedge clk_sys);
    e0 = err_cnt;
    send_frame(8'h1C, 0, 0);
    model_frame(8'h1C, 1'b1);
    check("post_rst_key", 32'(ps2_key), 32'h61C);
    check("post_rst_model", 32'(ps2_key), 32'(m_key));
    check("post_rst_err", 32'(err_cnt - e0), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
